adsr_envelope: RTL and testbench
================================

Name:
adsr_envelope

Overview:
- Per-voice ADSR envelope generator plus VCA (voltage-controlled amplifier: gain stage), directly downstream of the oscillator.
- Consumes the oscillator's signed sample stream and the per-sample tick `step_in`.
- Advances an attack/decay/sustain/release envelope once per tick, driven by a note gate.
- Outputs the oscillator sample scaled by the current envelope level; feeds the voice mixer.

Parameters:
- DATA_WIDTH, 32, width of signed sample in/out.
- ENV_WIDTH, 16, width of unsigned envelope level. ENV_MAX = 2^ENV_WIDTH-1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- step_in  in  1  sample tick, one-cycle pulse; envelope updates only on cycles where it is 1.
- gate_in  in  1  note held (1) / released (0); level-sensitive.
- attack_step  in  ENV_WIDTH  level increment per tick in ATTACK; 0 = instant.
- decay_step  in  ENV_WIDTH  level decrement per tick in DECAY; 0 = instant.
- sustain_level  in  ENV_WIDTH  SUSTAIN level, tracked live.
- release_step  in  ENV_WIDTH  level decrement per tick in RELEASE; 0 = instant.
- data_in  in  DATA_WIDTH signed  oscillator sample.
- data_out  out  DATA_WIDTH signed  enveloped sample.
- env_out  out  ENV_WIDTH  current envelope level.
- active_out  out  1  1 when state != IDLE.

Behaviour:
- Reset: state IDLE; env_out 0; active_out 0; data_out 0; all VCA pipeline registers 0. Reset mid-note aborts immediately, no release tail.
- Non-tick cycles: state and level hold.
- FSM states: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE. Evaluated only on step_in=1 cycles, in the priority order below.
- Gate priority 1 (beats any threshold transition in the same tick):
  - gate_in=1 in IDLE or RELEASE -> ATTACK. Level is NOT reset (legato retrigger from current level). The increment is applied from the next tick.
  - gate_in=0 in ATTACK, DECAY or SUSTAIN -> RELEASE. The decrement is applied from the next tick.
- ATTACK: if attack_step=0 or level+attack_step >= ENV_MAX, then level=ENV_MAX and -> DECAY. Otherwise level += attack_step. Sum is computed at ENV_WIDTH+1 bits; no wrap.
- DECAY: if decay_step=0 or level <= sustain_level+decay_step, then level=sustain_level and -> SUSTAIN. Otherwise level -= decay_step.
  - Compare is computed at ENV_WIDTH+1 bits; no underflow.
  - sustain_level above the current level also snaps to sustain_level.
- SUSTAIN: level = sustain_level on every tick (live tracking).
- RELEASE: if release_step=0 or level <= release_step, then level=0 and -> IDLE. Otherwise level -= release_step.
- IDLE: level 0.
- Pulse between ticks: a gate pulse low->high occurring entirely between two ticks is not seen. This is by design.
- active_out is registered from state, so it updates in the cycle after the state change.
- VCA, 2-stage pipeline, independent of step_in:
  - Stage 1 registers prod = data_in * signed({1'b0, env_out}), full DATA_WIDTH+ENV_WIDTH+1 bits.
  - Stage 2 registers data_out = prod >>> ENV_WIDTH, truncated to DATA_WIDTH.
  - Latency from data_in/env_out to data_out is 2 clk.
  - Gain at ENV_MAX is (2^ENV_WIDTH-1)/2^ENV_WIDTH; no overflow is possible.

Decomposition:
- Shared package synth_pkg:
  - env_state_t enum (IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4), 3 bits.
  - ENV_WIDTH_DEFAULT constant.
- Sub-module env_vca: the 2-stage signed multiply/shift pipeline, parameters DATA_WIDTH and ENV_WIDTH.
- adsr_envelope holds the FSM and level register and instantiates env_vca.

Test Plan (ENV_WIDTH=16, DATA_WIDTH=32, step_in every 4 clk):
- Attack: attack_step=16384, gate 0->1, sustain_level=65535, decay_step=0.
  - Tick 1: ATTACK. Ticks 2-4: env 16384, 32768, 49152.
  - Tick 5: env 65535 -> DECAY. Tick 6: SUSTAIN at 65535. active_out=1 from the cycle after tick 1.
- Decay: from 65535 in DECAY, decay_step=10000, sustain_level=40000.
  - env 55535, 45535, then 40000 -> SUSTAIN.
  - Change sustain_level to 30000 -> env 30000 on the next tick.
- Release: SUSTAIN at 40000, release_step=20000, gate 1->0.
  - Tick: RELEASE at 40000. Then 20000. Then 0 -> IDLE. active_out=0 one clk later.
- Retrigger: RELEASE at env 20000, attack_step=16384, gate 0->1.
  - Tick: ATTACK at 20000. Next tick: 36384.
  - gate toggled with step_in held 0 -> no state or level change.
- VCA: env held at 32768.
  - data_in=1000000 -> data_out=500000 exactly 2 clk later.
  - data_in=-1000000 -> -500000.
  - At env 65535, data_in=65536 -> 65535. At env 0 -> data_out 0.
- Reset: assert rst mid-ATTACK (env 32768), gate held 1.
  - Next clk: env_out 0, data_out 0, active_out 0, IDLE.
  - After rst release, the first tick enters ATTACK from 0.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared definitions for the voice synthesis blocks.
// Holds the envelope state encoding and the default width constants used by
// adsr_envelope and its VCA sub-module.
package synth_pkg;

   localparam int ENV_WIDTH_DEFAULT  = 16;
   localparam int DATA_WIDTH_DEFAULT = 32;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ATTACK  = 3'd1,
      DECAY   = 3'd2,
      SUSTAIN = 3'd3,
      RELEASE = 3'd4
   } env_state_t;

endpackage

// File: rtl/env_vca.sv
// env_vca: two-stage signed gain stage applying the envelope level to a sample.
//   clk, rst      : clock, synchronous active-high reset (clears both stages)
//   data_in       : signed oscillator sample
//   env_in        : unsigned envelope level, treated as a gain of env_in/2^ENV_WIDTH
//   data_out      : signed scaled sample, 2 clk after data_in/env_in
module env_vca #(
   parameter int DATA_WIDTH = 32,
   parameter int ENV_WIDTH  = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic signed [DATA_WIDTH-1:0] data_in,
   input  logic        [ENV_WIDTH-1:0]  env_in,
   output logic signed [DATA_WIDTH-1:0] data_out
);

   localparam int PW = DATA_WIDTH + ENV_WIDTH + 1;

   logic signed [PW-1:0]         w_din_ext;
   logic signed [PW-1:0]         w_gain_ext;
   logic signed [PW-1:0]         r_prod;
   logic signed [DATA_WIDTH-1:0] r_out;
   logic                         w_unused_bits;

   // Gain is zero-extended so the level is always a non-negative multiplier.
   assign w_din_ext  = {{(ENV_WIDTH + 1){data_in[DATA_WIDTH-1]}}, data_in};
   assign w_gain_ext = {{(DATA_WIDTH + 1){1'b0}}, env_in};

   // Gain is strictly below 1, so the shifted product always fits DATA_WIDTH;
   // the fraction bits and the redundant sign bit are simply dropped.
   assign w_unused_bits = ^{r_prod[ENV_WIDTH-1:0], r_prod[PW-1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prod <= '0;
         r_out  <= '0;
      end else begin
         r_prod <= w_din_ext * w_gain_ext;
         r_out  <= r_prod[DATA_WIDTH+ENV_WIDTH-1:ENV_WIDTH];
      end
   end

   assign data_out = r_out;

endmodule

// File: rtl/adsr_envelope.sv
// adsr_envelope: per-voice ADSR envelope generator feeding a VCA.
//   clk, rst       : clock, synchronous active-high reset (aborts note, no tail)
//   step_in        : one-cycle sample tick; envelope advances only on ticks
//   gate_in        : note held (1) / released (0)
//   attack_step    : level increment per tick in ATTACK (0 = instant)
//   decay_step     : level decrement per tick in DECAY (0 = instant)
//   sustain_level  : SUSTAIN level, tracked live
//   release_step   : level decrement per tick in RELEASE (0 = instant)
//   data_in        : signed oscillator sample
//   data_out       : enveloped sample, 2 clk after data_in/env_out
//   env_out        : current envelope level
//   active_out     : 1 when not IDLE, one clk behind the state
//
// state   | meaning
// IDLE    | silent, level held at 0
// ATTACK  | rising toward ENV_MAX by attack_step per tick
// DECAY   | falling toward sustain_level by decay_step per tick
// SUSTAIN | level follows sustain_level while gate is held
// RELEASE | falling toward 0 by release_step per tick
module adsr_envelope
   import synth_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
   parameter int ENV_WIDTH  = ENV_WIDTH_DEFAULT
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         step_in,
   input  logic                         gate_in,
   input  logic        [ENV_WIDTH-1:0]  attack_step,
   input  logic        [ENV_WIDTH-1:0]  decay_step,
   input  logic        [ENV_WIDTH-1:0]  sustain_level,
   input  logic        [ENV_WIDTH-1:0]  release_step,
   input  logic signed [DATA_WIDTH-1:0] data_in,
   output logic signed [DATA_WIDTH-1:0] data_out,
   output logic        [ENV_WIDTH-1:0]  env_out,
   output logic                         active_out
);

   localparam logic [ENV_WIDTH-1:0] ENV_MAX = '1;

   env_state_t           r_state;
   logic [ENV_WIDTH-1:0] r_level;
   logic                 r_active;

   // One extra bit so neither the attack sum nor the decay floor can wrap.
   logic [ENV_WIDTH:0] w_attack_sum;
   logic [ENV_WIDTH:0] w_decay_floor;

   assign w_attack_sum  = {1'b0, r_level} + {1'b0, attack_step};
   assign w_decay_floor = {1'b0, sustain_level} + {1'b0, decay_step};

   // Gate changes take precedence over threshold moves; entering ATTACK or
   // RELEASE keeps the current level so retriggers and releases are smooth.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_level  <= '0;
         r_active <= 1'b0;
      end else begin
         r_active <= (r_state != IDLE);
         if (step_in) begin
            case (r_state)
               IDLE: begin
                  if (gate_in) r_state <= ATTACK;
                  else         r_level <= '0;
               end
               ATTACK: begin
                  if (!gate_in) begin
                     r_state <= RELEASE;
                  end else if ((attack_step == '0) || (w_attack_sum >= {1'b0, ENV_MAX})) begin
                     r_level <= ENV_MAX;
                     r_state <= DECAY;
                  end else begin
                     r_level <= w_attack_sum[ENV_WIDTH-1:0];
                  end
               end
               DECAY: begin
                  // Also catches sustain_level raised above the current level.
                  if (!gate_in) begin
                     r_state <= RELEASE;
                  end else if ((decay_step == '0) || ({1'b0, r_level} <= w_decay_floor)) begin
                     r_level <= sustain_level;
                     r_state <= SUSTAIN;
                  end else begin
                     r_level <= r_level - decay_step;
                  end
               end
               SUSTAIN: begin
                  if (!gate_in) r_state <= RELEASE;
                  else          r_level <= sustain_level;
               end
               RELEASE: begin
                  if (gate_in) begin
                     r_state <= ATTACK;
                  end else if ((release_step == '0) || (r_level <= release_step)) begin
                     r_level <= '0;
                     r_state <= IDLE;
                  end else begin
                     r_level <= r_level - release_step;
                  end
               end
               default: begin
                  r_state <= IDLE;
                  r_level <= '0;
               end
            endcase
         end
      end
   end

   assign env_out    = r_level;
   assign active_out = r_active;

   env_vca #(
      .DATA_WIDTH (DATA_WIDTH),
      .ENV_WIDTH  (ENV_WIDTH)
   ) u_vca (
      .clk      (clk),
      .rst      (rst),
      .data_in  (data_in),
      .env_in   (r_level),
      .data_out (data_out)
   );

endmodule

// File: tb/tb_adsr_envelope.sv
// Bench for adsr_envelope: directed walk through the envelope phases with
// literal expectations, then randomized stimulus, all compared every cycle
// against an arithmetic model of the envelope and gain stage.
module tb_adsr_envelope;

   logic               clk;
   logic               rst;
   logic               step_in;
   logic               gate_in;
   logic        [15:0] attack_step;
   logic        [15:0] decay_step;
   logic        [15:0] sustain_level;
   logic        [15:0] release_step;
   logic signed [31:0] data_in;
   logic signed [31:0] data_out;
   logic        [15:0] env_out;
   logic               active_out;

   adsr_envelope #(.DATA_WIDTH(32), .ENV_WIDTH(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .step_in       (step_in),
      .gate_in       (gate_in),
      .attack_step   (attack_step),
      .decay_step    (decay_step),
      .sustain_level (sustain_level),
      .release_step  (release_step),
      .data_in       (data_in),
      .data_out      (data_out),
      .env_out       (env_out),
      .active_out    (active_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_assert = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input longint act, input longint exp);
      n_assert++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Phases of the note, in plain integers.
   localparam int P_OFF  = 0;
   localparam int P_RISE = 1;
   localparam int P_FALL = 2;
   localparam int P_HOLD = 3;
   localparam int P_TAIL = 4;
   localparam int TOP    = 65535;

   int     m_env    = 0;
   int     m_phase  = P_OFF;
   int     m_active = 0;
   longint m_prod   = 0;
   longint m_out    = 0;

   always @(posedge clk) begin
      int a, d, s, r;
      if (rst) begin
         m_env = 0; m_phase = P_OFF; m_active = 0; m_prod = 0; m_out = 0;
      end else begin
         a = int'(attack_step);
         d = int'(decay_step);
         s = int'(sustain_level);
         r = int'(release_step);
         m_out    = m_prod / 65536;
         if ((m_prod < 0) && (m_prod % 65536 != 0)) m_out = m_out - 1; // floor division
         m_prod   = longint'(data_in) * longint'(m_env);
         m_active = (m_phase != P_OFF) ? 1 : 0;
         if (step_in) begin
            if (gate_in && (m_phase == P_OFF || m_phase == P_TAIL)) begin
               m_phase = P_RISE;
            end else if (!gate_in && (m_phase == P_RISE || m_phase == P_FALL || m_phase == P_HOLD)) begin
               m_phase = P_TAIL;
            end else begin
               case (m_phase)
                  P_OFF:  m_env = 0;
                  P_RISE: if (a == 0 || m_env + a >= TOP) begin m_env = TOP; m_phase = P_FALL; end
                          else m_env = m_env + a;
                  P_FALL: if (d == 0 || m_env <= s + d) begin m_env = s; m_phase = P_HOLD; end
                          else m_env = m_env - d;
                  P_HOLD: m_env = s;
                  default: if (r == 0 || m_env <= r) begin m_env = 0; m_phase = P_OFF; end
                           else m_env = m_env - r;
               endcase
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("env_model",    longint'(env_out),    longint'(m_env));
         check("active_model", longint'(active_out), longint'(m_active));
         check("data_model",   longint'(data_out),   m_out);
      end
   end

   task automatic tick();
      step_in = 1'b1;
      @(negedge clk);
      step_in = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic logic [15:0] pick_step();
      case ($urandom_range(0, 3))
         0:       return 16'd0;
         1:       return 16'($urandom_range(1, 255));
         2:       return 16'($urandom_range(256, 8000));
         default: return 16'($urandom_range(8000, 65535));
      endcase
   endfunction

   initial begin
      rst = 1'b1; step_in = 1'b0; gate_in = 1'b0;
      attack_step = '0; decay_step = '0; sustain_level = '0; release_step = '0;
      data_in = 32'sd1234;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      check("reset_env",    longint'(env_out),    0);
      check("reset_active", longint'(active_out), 0);
      check("reset_data",   longint'(data_out),   0);
      rst = 1'b0;

      // Attack to the top, then into sustain at full level.
      attack_step = 16'd16384; sustain_level = 16'd65535; decay_step = 16'd0;
      gate_in = 1'b1;
      tick();
      check("att_t1_env", longint'(env_out), 0);
      check("att_t1_active", longint'(active_out), 1);
      tick(); check("att_t2", longint'(env_out), 16384);
      tick(); check("att_t3", longint'(env_out), 32768);
      tick(); check("att_t4", longint'(env_out), 49152);
      tick(); check("att_t5", longint'(env_out), 65535);
      tick(); check("att_t6", longint'(env_out), 65535);

      // Decay toward sustain, live sustain tracking.
      do_reset();
      attack_step = 16'd0; decay_step = 16'd10000; sustain_level = 16'd40000;
      gate_in = 1'b1;
      tick(); tick();
      check("dec_peak", longint'(env_out), 65535);
      tick(); check("dec_1", longint'(env_out), 55535);
      tick(); check("dec_2", longint'(env_out), 45535);
      tick(); check("dec_snap", longint'(env_out), 40000);
      sustain_level = 16'd30000;
      tick(); check("sus_track", longint'(env_out), 30000);
      sustain_level = 16'd40000;
      tick(); check("sus_back", longint'(env_out), 40000);

      // Release, then retrigger from mid-release.
      release_step = 16'd20000; gate_in = 1'b0;
      tick(); check("rel_enter", longint'(env_out), 40000);
      tick(); check("rel_1", longint'(env_out), 20000);
      attack_step = 16'd16384; gate_in = 1'b1;
      tick(); check("retrig_enter", longint'(env_out), 20000);
      tick(); check("retrig_1", longint'(env_out), 36384);
      gate_in = 1'b0;
      repeat (3) @(negedge clk);
      gate_in = 1'b1;
      repeat (2) @(negedge clk);
      check("gate_no_tick_env", longint'(env_out), 36384);
      tick(); check("retrig_2", longint'(env_out), 52768);
      gate_in = 1'b0;
      tick(); check("rel2_enter", longint'(env_out), 52768);
      tick(); check("rel2_1", longint'(env_out), 32768);
      tick(); check("rel2_2", longint'(env_out), 12768);
      tick(); check("rel2_idle", longint'(env_out), 0);
      check("rel2_inactive", longint'(active_out), 0);

      // Gain stage.
      do_reset();
      attack_step = 16'd32768; sustain_level = 16'd65535; decay_step = 16'd0;
      release_step = 16'd0; gate_in = 1'b1;
      tick(); tick();
      check("vca_env_half", longint'(env_out), 32768);
      data_in = 32'sd1000000;
      repeat (2) @(negedge clk);
      check("vca_pos_half", longint'(data_out), 500000);
      data_in = -32'sd1000000;
      repeat (2) @(negedge clk);
      check("vca_neg_half", longint'(data_out), -500000);
      data_in = 32'sd65536;
      tick();
      check("vca_full", longint'(data_out), 65535);
      gate_in = 1'b0;
      tick(); tick();
      check("vca_zero", longint'(data_out), 0);

      // Reset mid-attack.
      do_reset();
      attack_step = 16'd16384; gate_in = 1'b1; data_in = 32'sd1000;
      tick(); tick(); tick();
      check("rst_pre_env", longint'(env_out), 32768);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_env",    longint'(env_out),    0);
      check("rst_mid_data",   longint'(data_out),   0);
      check("rst_mid_active", longint'(active_out), 0);
      rst = 1'b0;
      tick(); check("rst_after_t1", longint'(env_out), 0);
      tick(); check("rst_after_t2", longint'(env_out), 16384);

      // Randomized traffic.
      for (int i = 0; i < 6000; i++) begin
         rst     = ($urandom_range(0, 599) == 0);
         step_in = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 15) == 0) gate_in = ~gate_in;
         if ($urandom_range(0, 40) == 0) attack_step   = pick_step();
         if ($urandom_range(0, 40) == 0) decay_step    = pick_step();
         if ($urandom_range(0, 40) == 0) release_step  = pick_step();
         if ($urandom_range(0, 30) == 0) sustain_level = 16'($urandom_range(0, 65535));
         data_in = $urandom();
         @(negedge clk);
      end
      rst = 1'b0; step_in = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
